// File: rtl/pipeline_perf_monitor_pkg.sv
// Shared definitions for the pipeline performance monitor.
//   - mon_state_e : monitor FSM state encoding (IDLE=0, RUN=1, HALTED=2)
//   - CNT_*       : counter indices, identical to the rd_sel_i encoding and
//                   to the overflow_o bit order
package pipeline_perf_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } mon_state_e;

  localparam int NUM_CNT = 4;

  localparam logic [1:0] CNT_CYCLE  = 2'd0;
  localparam logic [1:0] CNT_STALL  = 2'd1;
  localparam logic [1:0] CNT_FLUSH  = 2'd2;
  localparam logic [1:0] CNT_RETIRE = 2'd3;

endpackage

// File: rtl/pipeline_perf_monitor_if.sv
// Bundle of the per-cycle pipeline event inputs, control inputs and the
// monitor's read/status outputs.
//   slave  : the monitor (consumes events, drives status)
//   master : the CPU/bench side (drives events, observes status)
interface pipeline_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             jump_i;
  logic             branch_i;
  logic             flush_i;
  logic             wb_valid_i;
  logic             clear_i;
  logic [1:0]       rd_sel_i;
  logic [CNT_W-1:0] rd_data_o;
  logic [3:0]       overflow_o;
  logic             running_o;
  logic             halt_o;

  modport slave (
    input  start_i, stall_i, jump_i, branch_i, flush_i, wb_valid_i,
           clear_i, rd_sel_i,
    output rd_data_o, overflow_o, running_o, halt_o
  );

  modport master (
    output start_i, stall_i, jump_i, branch_i, flush_i, wb_valid_i,
           clear_i, rd_sel_i,
    input  rd_data_o, overflow_o, running_o, halt_o
  );

endinterface

// File: rtl/pipeline_perf_monitor_sat_counter.sv
// Saturating unsigned event counter with sticky overflow flag.
//   clk_i, rst_i : clock, async active-high reset
//   inc_i        : increment request for this edge
//   clr_i        : synchronous clear (wins over inc_i)
//   cnt_o        : current count
//   ovf_o        : set when an increment is attempted at the max value
module sat_counter
  import pipeline_perf_monitor_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor for the 5-stage MIPS pipeline. Counts run cycles,
// load-use stalls, flushes and retired instructions while the CPU runs, and
// raises a halt request once the cycle count reaches CYCLE_LIMIT.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : start/stall/jump/branch/flush/wb_valid/clear/rd_sel in,
//                  rd_data/overflow/running/halt out (all outputs registered)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | paused or never started; counters hold
// RUN     | CPU running; every edge counts a cycle plus qualified events
// HALTED  | cycle limit reached; only clear_i or reset leave this state
module pipeline_perf_monitor
  import pipeline_perf_monitor_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  pipeline_perf_monitor_if.slave  bus
);

  // A limit that cannot be represented in CNT_W bits can never be reached.
  localparam bit               LIMIT_EN  = (CYCLE_LIMIT != 0) &&
                                           ((CNT_W >= 31) || (CYCLE_LIMIT < (1 << CNT_W)));
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(CYCLE_LIMIT);

  mon_state_e       state_d, state_q;
  logic             running_d, running_q;
  logic             halt_d, halt_q;
  logic [CNT_W-1:0] rd_data_d, rd_data_q;

  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] inc;
  logic             count_en;
  logic [CNT_W-1:0] cycle_post;
  logic             limit_hit;

  // Nothing from a clear cycle is counted.
  assign count_en = (state_q == ST_RUN) && !bus.clear_i;

  always_comb begin
    inc             = '0;
    inc[CNT_CYCLE]  = count_en;
    // Bubbles inserted for jump/branch are control hazards, not load-use stalls.
    inc[CNT_STALL]  = count_en && bus.stall_i && !bus.jump_i && !bus.branch_i;
    inc[CNT_FLUSH]  = count_en && bus.flush_i;
    inc[CNT_RETIRE] = count_en && bus.wb_valid_i;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc[g]),
      .clr_i (bus.clear_i),
      .cnt_o (cnt[g]),
      .ovf_o (ovf[g])
    );
  end

  // Cycle count as it will be after this edge (saturating), so halt rises on
  // the same edge that the counter reaches the limit.
  assign cycle_post = (&cnt[CNT_CYCLE]) ? cnt[CNT_CYCLE] : cnt[CNT_CYCLE] + 1'b1;
  assign limit_hit  = LIMIT_EN && (cycle_post == LIMIT_VAL);

  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:   if (bus.start_i) state_d = ST_RUN;
        ST_RUN: begin
          if (limit_hit)         state_d = ST_HALTED;
          else if (!bus.start_i) state_d = ST_IDLE;
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    halt_d    = (state_d == ST_HALTED);
  end

  // Read returns the register contents before this edge's update/clear.
  assign rd_data_d = cnt[bus.rd_sel_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      halt_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      halt_q    <= halt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.overflow_o = ovf;
  assign bus.running_o  = running_q;
  assign bus.halt_o     = halt_q;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
module tb_pipeline_perf_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_perf_monitor_if #(.CNT_W(32)) ifa ();
  pipeline_perf_monitor_if #(.CNT_W(4))  ifb ();

  pipeline_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(30)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  pipeline_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  typedef struct {
    logic [31:0] rd;
    logic        running;
    logic        halt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          passes = 0;
  int          m_state = 0;          // 0 idle, 1 run, 2 halted
  logic [31:0] m_cnt [4];

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    sb_q.delete();
  endtask

  // Reference model step for dut_a using the inputs present at the coming edge.
  task automatic model_step(output exp_t e);
    e.rd = m_cnt[ifa.rd_sel_i];
    if (ifa.clear_i) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
      m_state = 0;
    end else if (m_state == 1) begin
      m_cnt[0] = m_cnt[0] + 1;
      if (ifa.stall_i && !ifa.jump_i && !ifa.branch_i) m_cnt[1] = m_cnt[1] + 1;
      if (ifa.flush_i)    m_cnt[2] = m_cnt[2] + 1;
      if (ifa.wb_valid_i) m_cnt[3] = m_cnt[3] + 1;
      if (m_cnt[0] == 32'd30)  m_state = 2;
      else if (!ifa.start_i)   m_state = 0;
    end else if (m_state == 0 && ifa.start_i) begin
      m_state = 1;
    end
    e.running = (m_state == 1);
    e.halt    = (m_state == 2);
  endtask

  task automatic tick_a();
    exp_t e, got;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    checks++;
    if (ifa.rd_data_o !== got.rd)
      $display("FAIL a_rd_data got %0d exp %0d t=%0t", ifa.rd_data_o, got.rd, $time);
    else passes++;
    checks++;
    if (ifa.running_o !== got.running)
      $display("FAIL a_running got %0b exp %0b t=%0t", ifa.running_o, got.running, $time);
    else passes++;
    checks++;
    if (ifa.halt_o !== got.halt)
      $display("FAIL a_halt got %0b exp %0b t=%0t", ifa.halt_o, got.halt, $time);
    else passes++;
    checks++;
    if (ifa.overflow_o !== 4'b0000)
      $display("FAIL a_overflow got %b exp 0000 t=%0t", ifa.overflow_o, $time);
    else passes++;
  endtask

  task automatic tick_b();
    @(posedge clk); #1;
  endtask

  task automatic set_events_a(input logic [4:0] ev);
    ifa.stall_i    = ev[4];
    ifa.branch_i   = ev[3];
    ifa.jump_i     = ev[2];
    ifa.flush_i    = ev[1];
    ifa.wb_valid_i = ev[0];
  endtask

  task automatic clear_a();
    ifa.start_i = 1'b0;
    ifa.clear_i = 1'b1;
    tick_a();
    ifa.clear_i = 1'b0;
  endtask

  task automatic test_reset();
    ifa.start_i = 0; ifa.clear_i = 0; ifa.rd_sel_i = 0; set_events_a(5'b0);
    ifb.start_i = 0; ifb.clear_i = 0; ifb.rd_sel_i = 0;
    ifb.stall_i = 0; ifb.branch_i = 0; ifb.jump_i = 0; ifb.flush_i = 0; ifb.wb_valid_i = 0;
    rst = 1'b1;
    #12;
    checks++;
    if ({ifa.rd_data_o, ifa.overflow_o, ifa.running_o, ifa.halt_o} !== 38'd0)
      $display("FAIL reset_a got rd=%0d ovf=%b run=%b halt=%b exp all 0",
               ifa.rd_data_o, ifa.overflow_o, ifa.running_o, ifa.halt_o);
    else passes++;
    checks++;
    if ({ifb.rd_data_o, ifb.overflow_o, ifb.running_o, ifb.halt_o} !== 10'd0)
      $display("FAIL reset_b got rd=%0d ovf=%b run=%b halt=%b exp all 0",
               ifb.rd_data_o, ifb.overflow_o, ifb.running_o, ifb.halt_o);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_run_to_halt();
    int n = 0;
    ifa.start_i  = 1'b1;
    ifa.rd_sel_i = 2'd0;
    while (n < 50 && ifa.halt_o !== 1'b1) begin
      tick_a();
      n++;
    end
    checks++;
    if (n != 31) $display("FAIL halt_edge got %0d exp 31", n);
    else passes++;
    repeat (3) tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd30) $display("FAIL halt_cycles_hold got %0d exp 30", ifa.rd_data_o);
    else passes++;
    checks++;
    if (ifa.running_o !== 1'b0) $display("FAIL halt_running got %0b exp 0", ifa.running_o);
    else passes++;
  endtask

  task automatic test_clear();
    ifa.start_i  = 1'b0;   // ignored while halted
    ifa.rd_sel_i = 2'd0;
    ifa.clear_i  = 1'b1;
    tick_a();
    ifa.clear_i = 1'b0;
    checks++;
    if (ifa.rd_data_o !== 32'd30) $display("FAIL clear_read_preclear got %0d exp 30", ifa.rd_data_o);
    else passes++;
    for (int s = 0; s < 4; s++) begin
      ifa.rd_sel_i = 2'(s);
      tick_a();
      checks++;
      if (ifa.rd_data_o !== 32'd0) $display("FAIL clear_cnt%0d got %0d exp 0", s, ifa.rd_data_o);
      else passes++;
    end
    checks++;
    if (ifa.halt_o !== 1'b0) $display("FAIL clear_halt got %0b exp 0", ifa.halt_o);
    else passes++;
    ifa.rd_sel_i = 2'd0;
    ifa.start_i  = 1'b1;
    repeat (4) tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd2) $display("FAIL clear_resume got %0d exp 2", ifa.rd_data_o);
    else passes++;
  endtask

  task automatic test_events();
    logic [4:0] ev_tab [6];
    ev_tab = '{5'b10000, 5'b11000, 5'b10000, 5'b00011, 5'b00001, 5'b00111};
    clear_a();
    ifa.start_i = 1'b1;
    tick_a();
    foreach (ev_tab[i]) begin
      set_events_a(ev_tab[i]);
      ifa.rd_sel_i = 2'(i % 4);
      tick_a();
    end
    set_events_a(5'b0);
    ifa.start_i = 1'b0;
    tick_a();
    ifa.rd_sel_i = 2'd1; tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd2) $display("FAIL events_stalls got %0d exp 2", ifa.rd_data_o);
    else passes++;
    ifa.rd_sel_i = 2'd2; tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd2) $display("FAIL events_flushes got %0d exp 2", ifa.rd_data_o);
    else passes++;
    ifa.rd_sel_i = 2'd3; tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd3) $display("FAIL events_retired got %0d exp 3", ifa.rd_data_o);
    else passes++;
    ifa.rd_sel_i = 2'd0; tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd7) $display("FAIL events_cycles got %0d exp 7", ifa.rd_data_o);
    else passes++;
  endtask

  task automatic test_pause();
    int n = 0;
    clear_a();
    ifa.rd_sel_i = 2'd0;
    while (n < 80 && ifa.halt_o !== 1'b1) begin
      ifa.start_i = !(n >= 10 && n < 15);
      tick_a();
      n++;
    end
    checks++;
    if (n != 36) $display("FAIL pause_halt_edge got %0d exp 36", n);
    else passes++;
    tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd30) $display("FAIL pause_cycles got %0d exp 30", ifa.rd_data_o);
    else passes++;
  endtask

  task automatic test_saturate();
    ifb.start_i    = 1'b1;
    ifb.wb_valid_i = 1'b1;
    tick_b();
    repeat (15) tick_b();
    checks++;
    if (ifb.overflow_o !== 4'b0000) $display("FAIL sat_no_ovf_at_max got %b exp 0000", ifb.overflow_o);
    else passes++;
    ifb.rd_sel_i = 2'd3;
    repeat (5) tick_b();
    checks++;
    if (ifb.rd_data_o !== 4'd15) $display("FAIL sat_retired_run got %0d exp 15", ifb.rd_data_o);
    else passes++;
    ifb.start_i    = 1'b0;
    ifb.wb_valid_i = 1'b0;
    tick_b();
    tick_b();
    checks++;
    if (ifb.overflow_o !== 4'b1001) $display("FAIL sat_overflow got %b exp 1001", ifb.overflow_o);
    else passes++;
    checks++;
    if (ifb.rd_data_o !== 4'd15) $display("FAIL sat_retired got %0d exp 15", ifb.rd_data_o);
    else passes++;
    ifb.rd_sel_i = 2'd0;
    tick_b();
    checks++;
    if (ifb.rd_data_o !== 4'd15) $display("FAIL sat_cycles got %0d exp 15", ifb.rd_data_o);
    else passes++;
    checks++;
    if (ifb.halt_o !== 1'b0) $display("FAIL sat_no_halt got %0b exp 0", ifb.halt_o);
    else passes++;
  endtask

  task automatic test_async_reset();
    clear_a();
    ifa.start_i  = 1'b1;
    ifa.rd_sel_i = 2'd0;
    repeat (7) tick_a();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifa.rd_data_o, ifa.overflow_o, ifa.running_o, ifa.halt_o} !== 38'd0)
      $display("FAIL async_rst_immediate got rd=%0d run=%b halt=%b exp 0",
               ifa.rd_data_o, ifa.running_o, ifa.halt_o);
    else passes++;
    checks++;
    if (ifb.overflow_o !== 4'b0000) $display("FAIL async_rst_b_ovf got %b exp 0000", ifb.overflow_o);
    else passes++;
    @(posedge clk); #3;
    rst = 1'b0;
    model_reset();
    repeat (4) tick_a();
    checks++;
    if (ifa.rd_data_o !== 32'd2) $display("FAIL async_rst_recount got %0d exp 2", ifa.rd_data_o);
    else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_to_halt();
    test_clear();
    test_events();
    test_pause();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
